// File: rtl/bag_sequencer_if.sv
// Piece hand-off bundle between the bag sequencer (slave) and the game controller (master).
// Preview signals exist only when BAG_SEQUENCER_PREVIEW_EN is defined.
interface bag_sequencer_if;
    // Handshake: a piece moves on a rising clk edge where piece_valid && piece_take.
    // piece_take while !piece_valid is ignored; piece holds steady until taken.
    logic       enable;
    logic       flush;
    logic       piece_take;
    logic       piece_valid;
    logic [2:0] piece;
    logic       fill_busy;
    logic [7:0] bags_served;
`ifdef BAG_SEQUENCER_PREVIEW_EN
    logic       preview_valid;
    logic [2:0] preview_piece;

    modport master (
        output enable, flush, piece_take,
        input  piece_valid, piece, fill_busy, bags_served, preview_valid, preview_piece
    );
    modport slave (
        input  enable, flush, piece_take,
        output piece_valid, piece, fill_busy, bags_served, preview_valid, preview_piece
    );
`else
    modport master (
        output enable, flush, piece_take,
        input  piece_valid, piece, fill_busy, bags_served
    );
    modport slave (
        input  enable, flush, piece_take,
        output piece_valid, piece, fill_busy, bags_served
    );
`endif
endinterface

// File: rtl/bag_sequencer.sv
// Seven-bag tetromino randomiser: LFSR-driven staging fill, double-buffered active bag.
// Define BAG_SEQUENCER_PREVIEW_EN to add preview_valid/preview_piece.
module bag_sequencer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter logic [2:0]  NONE_CODE = 3'b111
) (
    input logic            clk,
    input logic            reset,
    bag_sequencer_if.slave bus
);
    // An all-zero Galois LFSR would lock up, so zero falls back to the default seed.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [15:0] lfsr;
    logic [2:0]  stg_slot [8];
    logic [7:0]  stg_flag;
    logic [2:0]  stg_count;
    logic [2:0]  act_slot [8];
    logic        act_valid;
    logic [2:0]  act_idx;
    logic [7:0]  bags_served;

    logic [2:0]  cand;
    logic        stg_full;
    logic        take;
    logic        last_take;
    logic        transfer;
    logic        accept;

    always_comb begin
        cand      = lfsr[2:0];
        stg_full  = (stg_count == 3'd7);
        take      = act_valid & bus.piece_take;
        last_take = take & (act_idx == 3'd6);
        // Staging moves over when active is empty or is being emptied on this very edge.
        transfer  = stg_full & (~act_valid | last_take);
        accept    = bus.enable & ~stg_full & (cand != 3'd7) & ~stg_flag[cand];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_valid   <= 1'b0;
            act_idx     <= 3'd0;
            stg_flag    <= 8'h00;
            stg_count   <= 3'd0;
            bags_served <= 8'h00;
        end else if (bus.flush) begin
            act_valid <= 1'b0;
            act_idx   <= 3'd0;
            stg_flag  <= 8'h00;
            stg_count <= 3'd0;
        end else if (transfer) begin
            act_slot    <= stg_slot;
            act_valid   <= 1'b1;
            act_idx     <= 3'd0;
            stg_flag    <= 8'h00;
            stg_count   <= 3'd0;
            bags_served <= bags_served + 8'd1;
        end else begin
            if (take) begin
                act_valid <= ~last_take;
                act_idx   <= last_take ? 3'd0 : act_idx + 3'd1;
            end
            if (accept) begin
                stg_flag[cand]      <= 1'b1;
                stg_slot[stg_count] <= cand;
                stg_count           <= stg_count + 3'd1;
            end
        end
    end

    assign bus.piece_valid = act_valid;
    assign bus.piece       = act_valid ? act_slot[act_idx] : NONE_CODE;
    assign bus.fill_busy   = ~stg_full;
    assign bus.bags_served = bags_served;

`ifdef BAG_SEQUENCER_PREVIEW_EN
    logic preview_in_active;
    logic preview_in_staging;

    // At the last active slot the following piece is the head of the staging bag.
    assign preview_in_active  = act_valid & (act_idx != 3'd6);
    assign preview_in_staging = act_valid & (act_idx == 3'd6) & stg_full;
    assign bus.preview_valid  = preview_in_active | preview_in_staging;
    assign bus.preview_piece  = preview_in_active  ? act_slot[act_idx + 3'd1] :
                                preview_in_staging ? stg_slot[0] : NONE_CODE;
`endif
endmodule

// File: tb/tb_bag_sequencer.sv
// Directed bench for bag_sequencer: reset, latency, bag permutations, enable/flush, back-to-back bags.
// Preview checks compile in when BAG_SEQUENCER_PREVIEW_EN is defined.
module tb_bag_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    bag_sequencer_if bus ();
    bag_sequencer_if bus0 ();

    assign bus0.enable     = bus.enable;
    assign bus0.flush      = bus.flush;
    assign bus0.piece_take = bus.piece_take;

    bag_sequencer u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
    bag_sequencer #(.SEED(16'h0000)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.piece_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check(tag, bus.piece_valid, 1);
    endtask

    // Freeze filling as soon as a bag arrives and drain it; exactly one permutation must come out.
    task automatic serve_frozen(input string tag);
        int cnt = 0;
        logic [7:0] mask = 8'h00;
        wait_valid({tag, "_valid"});
        bus.enable = 1'b0;
        while (bus.piece_valid === 1'b1 && cnt < 10) begin
            mask[bus.piece] = 1'b1;
            bus.piece_take = 1'b1;
            step();
            cnt++;
        end
        bus.piece_take = 1'b0;
        check({tag, "_count"}, cnt, 7);
        check({tag, "_perm"}, mask, 8'h7F);
        bus.enable = 1'b1;
    endtask

    initial begin
        logic [15:0] st;
        logic [7:0]  flags;
        logic [7:0]  mask;
        int          k;
        int          n;
        logic [2:0]  exp_piece;
`ifdef BAG_SEQUENCER_PREVIEW_EN
        logic [2:0]  pv;
`endif

        reset = 1'b1;
        bus.enable = 1'b1;
        bus.flush = 1'b0;
        bus.piece_take = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_valid", bus.piece_valid, 0);
        check("rst_piece", bus.piece, 3'b111);
        check("rst_fill_busy", bus.fill_busy, 1);
        check("rst_bags", bus.bags_served, 0);
        check("rst_valid_seed0", bus0.piece_valid, 0);
`ifdef BAG_SEQUENCER_PREVIEW_EN
        check("rst_pv_valid", bus.preview_valid, 0);
        check("rst_pv_piece", bus.preview_piece, 3'b111);
`endif

        // Reference fill of the first bag from SEED=ACE1 with enable held high
        st = 16'hACE1;
        flags = 8'h00;
        k = 0;
        while (exp_q.size() < 7) begin
            k++;
            if (st[2:0] != 3'd7 && !flags[st[2:0]]) begin
                flags[st[2:0]] = 1'b1;
                exp_q.push_back(st[2:0]);
            end
            st = lfsr_next(st);
        end

        reset = 1'b0;
        n = 0;
        while (bus.piece_valid !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("first_latency", n, k + 1);
        check("first_valid_seed0", bus0.piece_valid, 1);

        // Four bags, taking every cycle once valid
        for (int g = 0; g < 4; g++) begin
            mask = 8'h00;
            for (int p = 0; p < 7; p++) begin
                wait_valid("t2_valid");
                if (p == 0) check("t2_bags", bus.bags_served, g + 1);
                check("t2_code_lt7", (bus.piece != 3'd7), 1);
                mask[bus.piece] = 1'b1;
                if (g == 0) begin
                    exp_piece = exp_q.pop_front();
                    check("t2_bag0_order", bus.piece, exp_piece);
                    check("t6_seed0_order", bus0.piece, exp_piece);
                end
                bus.piece_take = 1'b1;
                step();
                bus.piece_take = 1'b0;
            end
            check("t2_perm", mask, 8'h7F);
        end

        // Fresh start for flush / back-to-back / enable tests
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;

        // Flush after 3 takes, with a take on the flush cycle
        wait_valid("t4_valid");
        check("t4_bags_before", bus.bags_served, 1);
        bus.piece_take = 1'b1;
        repeat (3) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.piece_take = 1'b0;
        check("t4_flush_valid", bus.piece_valid, 0);
        check("t4_flush_piece", bus.piece, 3'b111);
        check("t4_flush_fill_busy", bus.fill_busy, 1);
        check("t4_flush_bags", bus.bags_served, 1);

        // Back-to-back bags: staging full when the last active piece goes
        wait_valid("t5_valid");
        check("t5_bags_new", bus.bags_served, 2);
        n = 0;
        while (bus.fill_busy !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        check("t5_staging_full", bus.fill_busy, 0);
        mask = 8'h00;
        for (int p = 0; p < 7; p++) begin
            mask[bus.piece] = 1'b1;
`ifdef BAG_SEQUENCER_PREVIEW_EN
            pv = bus.preview_piece;
            check("t6_pv_valid", bus.preview_valid, 1);
`endif
            bus.piece_take = 1'b1;
            step();
            bus.piece_take = 1'b0;
            check("t5_valid_cont", bus.piece_valid, 1);
`ifdef BAG_SEQUENCER_PREVIEW_EN
            check("t6_pv_match", bus.piece, pv);
`endif
        end
        check("t5_perm", mask, 8'h7F);
        check("t5_bags_once", bus.bags_served, 3);

        // Fill frozen right after the transfer; current bag still served
        bus.enable = 1'b0;
        mask = 8'h00;
        for (int p = 0; p < 7; p++) begin
            check("t3_valid", bus.piece_valid, 1);
            check("t3_fill_busy", bus.fill_busy, 1);
            mask[bus.piece] = 1'b1;
            bus.piece_take = 1'b1;
            step();
            bus.piece_take = 1'b0;
        end
        check("t3_perm", mask, 8'h7F);
        bus.piece_take = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t3_starved_valid", bus.piece_valid, 0);
            check("t3_starved_piece", bus.piece, 3'b111);
        end
        check("t3_starved_fill_busy", bus.fill_busy, 1);
        bus.piece_take = 1'b0;
        bus.enable = 1'b1;

        // Takes while empty were ignored: the next bag is whole
        serve_frozen("t3_resume");
        check("t3_bags", bus.bags_served, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
